// File: rtl/pc_return_stack_if.sv
// Bundle between the instruction controller / datapath and the PC + return-stack block.
// The master drives the controls and target; the slave returns the PC and the stack status.
interface pc_return_stack_if #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic              stall;
    logic [1:0]        pc_src;
    logic              stack_push;
    logic              stack_pop;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   depth;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              unf;
    logic              proto_err;

    modport master (
        output stall, pc_src, stack_push, stack_pop, target,
        input  pc, depth, empty, full, ovf, unf, proto_err
    );

    modport slave (
        input  stall, pc_src, stack_push, stack_pop, target,
        output pc, depth, empty, full, ovf, unf, proto_err
    );
endinterface

// File: rtl/pc_return_stack.sv
// Program-counter register with a hardware return-address stack.
// Handles sequential fetch, jump, call (push PC+1) and return (pop), with sticky error flags.
module pc_return_stack #(
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 8,
    parameter int RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_return_stack_if.slave     bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_stack [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_ovf;
    logic              r_unf;
    logic              r_proto_err;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [SP_W-1:0]   w_sp_next;
    logic              w_empty;
    logic              w_full;
    logic              w_push_en;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_perr_set;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == SP_W'(DEPTH));
    assign w_wr_idx = IDX_W'(r_sp);
    assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));

    always_comb begin
        w_pc_next  = r_pc;
        w_sp_next  = r_sp;
        w_push_en  = 1'b0;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        w_perr_set = 1'b0;
        if (!bus.stall) begin
            unique case (bus.pc_src)
                2'b00: w_pc_next = w_pc_inc;
                2'b01: begin
                    w_pc_next = bus.target;
                    if (bus.stack_push) begin
                        if (w_full) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_push_en = 1'b1;
                            w_sp_next = r_sp + SP_W'(1);
                        end
                    end
                end
                2'b10: begin
                    // A missing pop strobe still pops; it only raises the protocol flag.
                    if (w_empty) begin
                        w_pc_next = w_pc_inc;
                        w_unf_set = 1'b1;
                    end else begin
                        w_pc_next = r_stack[w_rd_idx];
                        w_sp_next = r_sp - SP_W'(1);
                        if (!bus.stack_pop) begin
                            w_perr_set = 1'b1;
                        end
                    end
                end
                default: w_pc_next = r_pc;
            endcase
            if ((bus.stack_push && (bus.pc_src != 2'b01)) ||
                (bus.stack_pop  && (bus.pc_src != 2'b10))) begin
                w_perr_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= ADDR_W'(RESET_PC);
            r_sp        <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_sp        <= w_sp_next;
            r_ovf       <= r_ovf | w_ovf_set;
            r_unf       <= r_unf | w_unf_set;
            r_proto_err <= r_proto_err | w_perr_set;
        end
    end

    // Stack storage needs no reset: entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (rst_n && w_push_en) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign bus.pc        = r_pc;
    assign bus.depth     = r_sp;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.ovf       = r_ovf;
    assign bus.unf       = r_unf;
    assign bus.proto_err = r_proto_err;
endmodule
